pwm_deadtime_gate: RTL

- Sits directly downstream of the FOC core's PWM outputs (pwm_en, pwm_a/b/c) and drives the six gate-driver inputs: high side and low side for each of phases A/B/C.
- Inserts programmable break-before-make dead time on every edge.
- Latches an external active-low driver fault, which forces all gates off until firmware clears it.
- The dead-time value and the fault-clear strobe come from the AXI-lite register bank.

---
 rtl/pwm_dt_pkg.sv | 16 +
 rtl/pwm_dt_phase.sv | 102 ++++++++++
 rtl/pwm_deadtime_gate.sv | 93 +++++++++
 3 files changed

// File: rtl/pwm_dt_pkg.sv
// Shared phase-state encoding and widths for the PWM dead-time gate.
// Glitch counter width is only used when PWM_DT_GLITCH_CNT_EN is defined.
package pwm_dt_pkg;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    LS_ON    = 3'd1,
    DT_TO_HS = 3'd2,
    HS_ON    = 3'd3,
    DT_TO_LS = 3'd4
  } phase_st_e;

  localparam int DT_W_DEF = 8;
  localparam int GLITCH_W = 16;

endpackage

// File: rtl/pwm_dt_phase.sv
// One half-bridge: break-before-make FSM with a dead-time counter, registered gate outputs.
// With PWM_DT_GLITCH_CNT_EN defined, o_swallow pulses when a dead-time state falls back to its origin.
module pwm_dt_phase
  import pwm_dt_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_run,
  input  logic            i_pwm,
  input  logic [DT_W-1:0] i_dt,
`ifdef PWM_DT_GLITCH_CNT_EN
  output logic            o_swallow,
`endif
  output logic            o_hs,
  output logic            o_ls
);

  localparam logic [DT_W-1:0] CNT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

  phase_st_e       r_st, w_st_nxt;
  logic [DT_W-1:0] r_cnt, w_cnt_nxt, w_load;
  logic            r_hs, r_ls;

  // A zero dead time still costs one cycle with both switches open.
  assign w_load = (i_dt == '0) ? CNT_ONE : i_dt;

  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    if (!i_run) begin
      w_st_nxt  = OFF;
      w_cnt_nxt = '0;
    end else begin
      case (r_st)
        OFF: begin
          w_st_nxt  = i_pwm ? DT_TO_HS : DT_TO_LS;
          w_cnt_nxt = w_load;
        end
        LS_ON: if (i_pwm) begin
          w_st_nxt  = DT_TO_HS;
          w_cnt_nxt = w_load;
        end
        HS_ON: if (!i_pwm) begin
          w_st_nxt  = DT_TO_LS;
          w_cnt_nxt = w_load;
        end
        DT_TO_HS: begin
          if (!i_pwm) begin
            w_st_nxt  = LS_ON;
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_ONE) begin
            w_st_nxt  = HS_ON;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        DT_TO_LS: begin
          if (i_pwm) begin
            w_st_nxt  = HS_ON;
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_ONE) begin
            w_st_nxt  = LS_ON;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        default: begin
          w_st_nxt  = OFF;
          w_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Gates decode from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= OFF;
      r_cnt <= '0;
      r_hs  <= 1'b0;
      r_ls  <= 1'b0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
      r_hs  <= (w_st_nxt == HS_ON);
      r_ls  <= (w_st_nxt == LS_ON);
    end
  end

  assign o_hs = r_hs;
  assign o_ls = r_ls;

`ifdef PWM_DT_GLITCH_CNT_EN
  assign o_swallow = i_run && (((r_st == DT_TO_HS) && !i_pwm) ||
                               ((r_st == DT_TO_LS) &&  i_pwm));
`endif

endmodule

// File: rtl/pwm_deadtime_gate.sv
// Six-gate driver front end: per-phase dead time, synchronised sticky driver fault.
// PWM_DT_GLITCH_CNT_EN adds glitch_cnt/glitch_cnt_clr, a saturating swallowed-pulse counter.
module pwm_deadtime_gate
  import pwm_dt_pkg::*;
#(
  parameter int DT_W   = DT_W_DEF,
  parameter int NUM_PH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_en,
  input  logic [NUM_PH-1:0]   pwm_in,
  input  logic [DT_W-1:0]     dt_cycles,
  input  logic                fault_n,
  input  logic                fault_clr,
`ifdef PWM_DT_GLITCH_CNT_EN
  input  logic                glitch_cnt_clr,
  output logic [GLITCH_W-1:0] glitch_cnt,
`endif
  output logic [NUM_PH-1:0]   gate_hs,
  output logic [NUM_PH-1:0]   gate_ls,
  output logic                fault_latched
);

  logic              r_fault_meta, r_fault_s, r_fault_lat;
  logic              w_run;
  logic [NUM_PH-1:0] w_hs, w_ls;
`ifdef PWM_DT_GLITCH_CNT_EN
  logic [NUM_PH-1:0] w_swallow;
`endif

  // Synchroniser presets to "no fault"; an active fault beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_meta <= 1'b1;
      r_fault_s    <= 1'b1;
      r_fault_lat  <= 1'b0;
    end else begin
      r_fault_meta <= fault_n;
      r_fault_s    <= r_fault_meta;
      if (!r_fault_s)
        r_fault_lat <= 1'b1;
      else if (fault_clr)
        r_fault_lat <= 1'b0;
    end
  end

  assign w_run = pwm_en & ~r_fault_lat & r_fault_s;

  for (genvar i = 0; i < NUM_PH; i++) begin : g_ph
    pwm_dt_phase #(.DT_W(DT_W)) u_phase (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_run     (w_run),
      .i_pwm     (pwm_in[i]),
      .i_dt      (dt_cycles),
`ifdef PWM_DT_GLITCH_CNT_EN
      .o_swallow (w_swallow[i]),
`endif
      .o_hs      (w_hs[i]),
      .o_ls      (w_ls[i])
    );
  end

  assign gate_hs       = w_hs;
  assign gate_ls       = w_ls;
  assign fault_latched = r_fault_lat;

`ifdef PWM_DT_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] r_glitch_cnt;
  logic [GLITCH_W:0]   w_glitch_sum;

  always_comb begin
    w_glitch_sum = {1'b0, r_glitch_cnt};
    for (int i = 0; i < NUM_PH; i++)
      w_glitch_sum = w_glitch_sum + {{GLITCH_W{1'b0}}, w_swallow[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_glitch_cnt <= '0;
    else if (glitch_cnt_clr)
      r_glitch_cnt <= '0;
    else if (w_glitch_sum[GLITCH_W])
      r_glitch_cnt <= '1;
    else
      r_glitch_cnt <= w_glitch_sum[GLITCH_W-1:0];
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule
